modmul_barrett: RTL and testbench

Pipelined modular multiplier for the Kyber modulus q = 3329. Each cycle it accepts two 12-bit residues and a sideband tag, and returns (A·B) mod q four enabled cycles later using Barrett reduction. It sits directly upstream of the butterfly add/subtract stage: it produces the twiddle product W·B, which the modular adder and subtractor then combine with A. Valid and tag pipelines travel alongside the data, so the controller can track which coefficient address each result belongs to.

---
 rtl/modmul_barrett_if.sv | 24 ++
 rtl/modmul_barrett.sv | 60 ++++++
 tb/tb_modmul_barrett.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/modmul_barrett_if.sv
// Operand/result bundle for the Kyber Barrett modular multiplier.
// The master drives operands, tag and enable; the slave returns results.
interface modmul_barrett_if #(
  parameter int TAG_W = 8
);
  logic             en;
  logic             in_valid;
  logic [11:0]      A;
  logic [11:0]      B;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [11:0]      C;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output en, in_valid, A, B, in_tag,
    input  out_valid, C, out_tag
  );

  modport slave (
    input  en, in_valid, A, B, in_tag,
    output out_valid, C, out_tag
  );
endinterface

// File: rtl/modmul_barrett.sv
// Four-stage pipelined (A*B) mod 3329 using Barrett reduction (m = 5039, k = 24).
// Valid and tag travel in lockstep with the data; en stalls every register.
module modmul_barrett #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  modmul_barrett_if.slave  bus
);
  localparam logic [23:0] Q24   = 24'd3329;
  localparam logic [13:0] Q14   = 14'd3329;
  localparam logic [36:0] M_BAR = 37'd5039;

  logic [23:0]      p1;
  logic [23:0]      p2;
  logic [11:0]      qhat2;
  logic [13:0]      r3;
  logic [11:0]      c4;
  logic [3:0]       valid_pipe;
  logic [TAG_W-1:0] tag_pipe [4];

  logic [11:0]      qhat_next;
  logic [13:0]      r_next;
  logic [11:0]      c_next;

  // Casts truncate deliberately: for illegal operands the result only needs to be defined.
  always_comb begin
    qhat_next = '0;
    r_next    = '0;
    c_next    = '0;
    qhat_next = 12'((37'(p1) * M_BAR) >> 24);
    r_next    = 14'(p2 - 24'(qhat2) * Q24);
    c_next    = (r3 >= Q14) ? 12'(r3 - Q14) : 12'(r3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1         <= '0;
      p2         <= '0;
      qhat2      <= '0;
      r3         <= '0;
      c4         <= '0;
      valid_pipe <= '0;
      for (int unsigned i = 0; i < 4; i++) tag_pipe[i] <= '0;
    end else if (bus.en) begin
      p1         <= 24'(bus.A) * 24'(bus.B);
      p2         <= p1;
      qhat2      <= qhat_next;
      r3         <= r_next;
      c4         <= c_next;
      valid_pipe <= {valid_pipe[2:0], bus.in_valid};
      tag_pipe[0] <= bus.in_tag;
      for (int unsigned i = 1; i < 4; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign bus.out_valid = valid_pipe[3];
  assign bus.C         = c4;
  assign bus.out_tag   = tag_pipe[3];
endmodule

// File: tb/tb_modmul_barrett.sv
// Scoreboard bench for modmul_barrett: the driver queues expected results,
// an independent monitor pops and compares whenever an enabled edge shows out_valid.
module tb_modmul_barrett;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  modmul_barrett_if #(.TAG_W(8)) bus ();

  modmul_barrett #(.TAG_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int c;
    int tag;
    int s;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   ecnt    = 0;
  int   n_acc   = 0;
  int   n_out   = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: one pop per enabled edge with out_valid; outputs must hold when en is low.
  initial begin : monitor
    bit   en_s, rs;
    int   prev_c = 0, prev_t = 0;
    bit   prev_v = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s = bus.en;
      rs   = reset;
      if (en_s && !rs) ecnt++;
      #1;
      if (!rs) begin
        if (!en_s) begin
          check("hold", bus.C == prev_c && bus.out_valid == prev_v && bus.out_tag == prev_t,
                int'(bus.C), prev_c);
        end else if (bus.out_valid) begin
          n_out++;
          if (sb.size() == 0) begin
            check("spurious_output", 1'b0, int'(bus.out_tag), -1);
          end else begin
            e = sb.pop_front();
            check("result_C", int'(bus.C) == e.c, int'(bus.C), e.c);
            check("out_tag", int'(bus.out_tag) == e.tag, int'(bus.out_tag), e.tag);
            check("latency", ecnt - e.s == 3, ecnt - e.s + 1, 4);
            check("C_range", bus.C < 12'd3329, int'(bus.C), 3328);
          end
        end
      end
      prev_c = int'(bus.C);
      prev_v = bus.out_valid;
      prev_t = int'(bus.out_tag);
    end
  end

  task automatic issue(input int a, input int b, input int tg, input bit v, input bit e,
                       input int exp_c);
    @(negedge clk);
    bus.A        = 12'(a);
    bus.B        = 12'(b);
    bus.in_tag   = 8'(tg);
    bus.in_valid = v;
    bus.en       = e;
    if (v && e) begin
      sb.push_back('{c: exp_c, tag: tg, s: ecnt + 1});
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 1'b0, 1'b1, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      idle(1);
      guard++;
    end
    check("drain_timeout", sb.size() == 0, sb.size(), 0);
  endtask

  // Reset asserted with en and in_valid high: reset must win and flush everything.
  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 12'd7;
    bus.B        = 12'd9;
    n_acc -= sb.size();
    sb.delete();
    for (int i = 0; i < cycles; i++) @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_out_valid", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
    check("rst_C", bus.C == 12'd0, int'(bus.C), 0);
    check("rst_out_tag", bus.out_tag == 8'd0, int'(bus.out_tag), 0);
  endtask

  function automatic int model(input int a, input int b);
    return (a * b) % 3329;
  endfunction

  initial begin : driver
    int nr, a, b;
    bit e, v;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.in_tag   = '0;
    repeat (2) @(negedge clk);
    #1;
    check("init_out_valid", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
    check("init_C", bus.C == 12'd0, int'(bus.C), 0);
    reset = 1'b0;
    idle(2);

    // Pipeline full of valids, then reset; nothing stale may follow.
    for (int i = 0; i < 4; i++) issue(100 + i, 200 + i, 50 + i, 1'b1, 1'b1, model(100 + i, 200 + i));
    pulse_reset(2);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("no_stale", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
    end

    // Known values, back-to-back.
    issue(3328, 3328, 1, 1'b1, 1'b1, 1);
    issue(1234, 2345, 2, 1'b1, 1'b1, 829);
    issue(17,   17,   3, 1'b1, 1'b1, 289);
    issue(0,    3000, 4, 1'b1, 1'b1, 0);
    // Correction path and bypass.
    issue(3328, 1,    5, 1'b1, 1'b1, 3328);
    issue(1,    1,    6, 1'b1, 1'b1, 1);
    issue(3328, 2,    7, 1'b1, 1'b1, 3327);
    drain();

    // Stall after the second issue; in_valid pulsed while stalled must be ignored.
    issue(11, 12, 10, 1'b1, 1'b1, model(11, 12));
    issue(13, 14, 11, 1'b1, 1'b1, model(13, 14));
    issue(99, 99, 99, 1'b1, 1'b0, 0);
    issue(98, 98, 98, 1'b0, 1'b0, 0);
    issue(97, 97, 97, 1'b1, 1'b0, 0);
    issue(15, 16, 12, 1'b1, 1'b1, model(15, 16));
    issue(3000, 3100, 13, 1'b1, 1'b1, model(3000, 3100));
    drain();

    // Randomised legal traffic with random en and in_valid.
    nr = 0;
    while (nr < 10000) begin
      a = int'($urandom_range(0, 3328));
      b = int'($urandom_range(0, 3328));
      e = ($urandom_range(0, 99) < 85);
      v = ($urandom_range(0, 99) < 75);
      issue(a, b, int'($urandom_range(0, 255)), v, e, model(a, b));
      if (v && e) nr++;
    end
    drain();

    // Reset while three ops are in flight, then a single fresh op.
    issue(500, 600, 20, 1'b1, 1'b1, model(500, 600));
    issue(700, 800, 21, 1'b1, 1'b1, model(700, 800));
    issue(900, 1000, 22, 1'b1, 1'b1, model(900, 1000));
    pulse_reset(1);
    issue(2, 5, 23, 1'b1, 1'b1, 10);
    drain();
    idle(6);

    check("out_count", n_out == n_acc, n_out, n_acc);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
